ysyx_22051468_mul_div: RTL and testbench

Iterative multiply/divide unit for the RV64M extension. It implements all eight M-extension operations and their W-variants with a radix-2 shift-add / restoring-divide datapath. It uses a valid/ready handshake on both sides. It sits in EX beside the single-cycle integer ALU, and the pipeline stalls on `in_ready`/`out_valid`.

---
 rtl/ysyx_22051468_mul_div_pkg.sv | 21 ++
 rtl/ysyx_22051468_mdu_step.sv | 31 +++
 rtl/ysyx_22051468_mul_div.sv | 174 +++++++++++++++++
 tb/tb_ysyx_22051468_mul_div.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_22051468_mul_div_pkg.sv
// Shared encodings for the RV64M iterative multiply/divide unit.
// funct3 operation codes and controller state encoding.
package ysyx_22051468_mul_div_pkg;

    localparam logic [2:0] MD_MUL    = 3'b000;
    localparam logic [2:0] MD_MULH   = 3'b001;
    localparam logic [2:0] MD_MULHSU = 3'b010;
    localparam logic [2:0] MD_MULHU  = 3'b011;
    localparam logic [2:0] MD_DIV    = 3'b100;
    localparam logic [2:0] MD_DIVU   = 3'b101;
    localparam logic [2:0] MD_REM    = 3'b110;
    localparam logic [2:0] MD_REMU   = 3'b111;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_CALC = 2'd1,
        MD_FIX  = 2'd2,
        MD_DONE = 2'd3
    } md_state_t;

endpackage

// File: rtl/ysyx_22051468_mdu_step.sv
// One radix-2 iteration: shift-add multiply or restoring divide.
// Divide leaves bit 0 clear; the caller merges in q_bit.
module ysyx_22051468_mdu_step #(
    parameter int WIDTH = 64
) (
    input  logic               is_div,
    input  logic [2*WIDTH-1:0] part,
    input  logic [WIDTH-1:0]   operand,
    output logic [2*WIDTH-1:0] next_part,
    output logic               q_bit
);

    logic [WIDTH:0] mul_sum;
    logic [WIDTH:0] rem_sh;
    logic [WIDTH:0] diff;

    always_comb begin
        mul_sum = {1'b0, part[2*WIDTH-1:WIDTH]}
                + (part[0] ? {1'b0, operand} : '0);
        rem_sh  = part[2*WIDTH-1:WIDTH-1];
        diff    = rem_sh - {1'b0, operand};
        q_bit   = ~diff[WIDTH];
        if (is_div) begin
            next_part = {(q_bit ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0]),
                         part[WIDTH-2:0], 1'b0};
        end else begin
            next_part = {mul_sum, part[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/ysyx_22051468_mul_div.sv
// Iterative RV64M multiply/divide unit with W-variants.
// Operands are held as magnitudes; signs are reapplied in FIX.
module ysyx_22051468_mul_div
    import ysyx_22051468_mul_div_pkg::*;
#(
    parameter int WIDTH     = 64,
    parameter int CNT_WIDTH = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_1,
    input  logic [WIDTH-1:0] op_2,
    input  logic [2:0]       funct3,
    input  logic             is_W_i,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result
);

    localparam int HALF = WIDTH / 2;
    localparam int W2   = 2 * WIDTH;

    function automatic logic [WIDTH-1:0] sext_half(
        input logic [HALF-1:0] v
    );
        return {{HALF{v[HALF-1]}}, v};
    endfunction

    md_state_t            state;
    logic [CNT_WIDTH-1:0] cnt;
    logic [W2-1:0]        part;
    logic [WIDTH-1:0]     operand;
    logic [2:0]           f3_r;
    logic                 w_r;
    logic                 neg_res;
    logic                 neg_rem;

    logic             div_op, sg1, sg2, s1, s2;
    logic             div_zero, div_ovf;
    logic [WIDTH-1:0] a_ext, b_ext, a_mag, b_mag;
    logic [WIDTH-1:0] min_val, spec_raw, spec_res;

    always_comb begin
        div_op = funct3[2];
        if (is_W_i) begin
            sg1   = div_op & ~funct3[0];
            sg2   = div_op & ~funct3[0];
            a_ext = sg1 ? sext_half(op_1[HALF-1:0])
                        : {{HALF{1'b0}}, op_1[HALF-1:0]};
            b_ext = sg2 ? sext_half(op_2[HALF-1:0])
                        : {{HALF{1'b0}}, op_2[HALF-1:0]};
        end else begin
            sg1   = (funct3 == MD_MULH) | (funct3 == MD_MULHSU)
                  | (funct3 == MD_DIV)  | (funct3 == MD_REM);
            sg2   = (funct3 == MD_MULH) | (funct3 == MD_DIV)
                  | (funct3 == MD_REM);
            a_ext = op_1;
            b_ext = op_2;
        end
        s1      = sg1 & a_ext[WIDTH-1];
        s2      = sg2 & b_ext[WIDTH-1];
        a_mag   = s1 ? -a_ext : a_ext;
        b_mag   = s2 ? -b_ext : b_ext;
        min_val = is_W_i ? {{(HALF+1){1'b1}}, {(HALF-1){1'b0}}}
                         : {1'b1, {(WIDTH-1){1'b0}}};
        div_zero = div_op & (b_ext == '0);
        div_ovf  = div_op & sg1 & (a_ext == min_val) & (&b_ext);
        if (funct3[1]) begin
            spec_raw = div_zero ? a_ext : '0;
        end else begin
            spec_raw = div_zero ? '1 : min_val;
        end
        spec_res = is_W_i ? sext_half(spec_raw[HALF-1:0]) : spec_raw;
    end

    logic [W2-1:0]    next_part;
    logic             q_bit;
    logic             div_r;

    assign div_r = f3_r[2];

    ysyx_22051468_mdu_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .is_div   (div_r),
        .part     (part),
        .operand  (operand),
        .next_part(next_part),
        .q_bit    (q_bit)
    );

    logic [W2-1:0]    prod, prod_s;
    logic [WIDTH-1:0] quo, rem, fix_raw, fix_res;

    // W multiplies run half the iterations, leaving the product offset by HALF
    always_comb begin
        prod    = w_r ? (part >> HALF) : part;
        prod_s  = neg_res ? -prod : prod;
        quo     = neg_res ? -part[WIDTH-1:0] : part[WIDTH-1:0];
        rem     = neg_rem ? -part[W2-1:WIDTH] : part[W2-1:WIDTH];
        fix_raw = '0;
        unique case (1'b1)
            f3_r[2] & f3_r[1]:  fix_raw = rem;
            f3_r[2] & ~f3_r[1]: fix_raw = quo;
            ~f3_r[2] & (w_r | (f3_r[1:0] == 2'b00)):
                fix_raw = prod_s[WIDTH-1:0];
            default:            fix_raw = prod_s[W2-1:WIDTH];
        endcase
        fix_res = w_r ? sext_half(fix_raw[HALF-1:0]) : fix_raw;
    end

    assign in_ready  = (state == MD_IDLE);
    assign out_valid = (state == MD_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= MD_IDLE;
            cnt        <= '0;
            part       <= '0;
            operand    <= '0;
            f3_r       <= '0;
            w_r        <= 1'b0;
            neg_res    <= 1'b0;
            neg_rem    <= 1'b0;
            out_result <= '0;
        end else if (flush) begin
            state <= MD_IDLE;
        end else begin
            unique case (state)
                MD_IDLE: if (in_valid) begin
                    f3_r    <= funct3;
                    w_r     <= is_W_i;
                    neg_res <= s1 ^ s2;
                    neg_rem <= s1;
                    if (div_zero | div_ovf) begin
                        out_result <= spec_res;
                        state      <= MD_DONE;
                    end else begin
                        if (div_op) begin
                            operand <= b_mag;
                            part    <= {{WIDTH{1'b0}},
                                        is_W_i ? (a_mag << HALF) : a_mag};
                        end else begin
                            operand <= a_mag;
                            part    <= {{WIDTH{1'b0}}, b_mag};
                        end
                        cnt   <= is_W_i ? CNT_WIDTH'(HALF - 1)
                                        : CNT_WIDTH'(WIDTH - 1);
                        state <= MD_CALC;
                    end
                end
                MD_CALC: begin
                    part <= next_part | {{(W2-1){1'b0}}, q_bit & div_r};
                    if (cnt == '0) begin
                        state <= MD_FIX;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                MD_FIX: begin
                    out_result <= fix_res;
                    state      <= MD_DONE;
                end
                MD_DONE: if (out_ready) begin
                    state <= MD_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_22051468_mul_div.sv
// Self-checking bench for the RV64M multiply/divide unit.
module tb_ysyx_22051468_mul_div;
    import ysyx_22051468_mul_div_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] op_1;
    logic [63:0] op_2;
    logic [2:0]  funct3;
    logic        is_w;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_result;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ysyx_22051468_mul_div #(
        .WIDTH(64),
        .CNT_WIDTH(7)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_1      (op_1),
        .op_2      (op_2),
        .funct3    (funct3),
        .is_W_i    (is_w),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_result(out_result)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic is_special(input logic [2:0] f, input logic w,
                                        input logic [63:0] a,
                                        input logic [63:0] b);
        logic sgn;
        sgn = (f == MD_DIV) || (f == MD_REM);
        if (!f[2]) return 1'b0;
        if (w)
            return (b[31:0] == 0) ||
                   (sgn && a[31:0] == 32'h8000_0000 && b[31:0] == '1);
        return (b == 0) || (sgn && a == 64'h8000_0000_0000_0000 && b == '1);
    endfunction

    function automatic logic [63:0] model(input logic [2:0] f, input logic w,
                                          input logic [63:0] a,
                                          input logic [63:0] b);
        logic signed [127:0] pa, pb, pr;
        longint      sa, sb;
        int          sa32, sb32;
        logic [31:0] ua, ub, r32;
        logic        ovf;
        if (w) begin
            ua = a[31:0];
            ub = b[31:0];
            sa32 = $signed(ua);
            sb32 = $signed(ub);
            ovf = (ua == 32'h8000_0000) && (ub == '1);
            case (f)
                MD_DIV:  r32 = (ub == 0) ? '1 : ovf ? 32'h8000_0000
                             : 32'(sa32 / sb32);
                MD_DIVU: r32 = (ub == 0) ? '1 : ua / ub;
                MD_REM:  r32 = (ub == 0) ? ua : ovf ? '0
                             : 32'(sa32 % sb32);
                MD_REMU: r32 = (ub == 0) ? ua : ua % ub;
                default: r32 = ua * ub;
            endcase
            return {{32{r32[31]}}, r32};
        end
        sa = a;
        sb = b;
        ovf = (a == 64'h8000_0000_0000_0000) && (b == '1);
        case (f)
            MD_MUL: return a * b;
            MD_MULH: begin
                pa = {{64{a[63]}}, a};
                pb = {{64{b[63]}}, b};
                pr = pa * pb;
                return pr[127:64];
            end
            MD_MULHSU: begin
                pa = {{64{a[63]}}, a};
                pb = {64'b0, b};
                pr = pa * pb;
                return pr[127:64];
            end
            MD_MULHU: begin
                pa = {64'b0, a};
                pb = {64'b0, b};
                pr = pa * pb;
                return pr[127:64];
            end
            MD_DIV:  return (b == 0) ? '1 : ovf ? a : 64'(sa / sb);
            MD_DIVU: return (b == 0) ? '1 : a / b;
            MD_REM:  return (b == 0) ? a : ovf ? '0 : 64'(sa % sb);
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    task automatic issue(input logic [2:0] f, input logic w,
                         input logic [63:0] a, input logic [63:0] b);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!in_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        op_1 = a;
        op_2 = b;
        funct3 = f;
        is_w = w;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 1;
        while (!out_valid && lat < 200) begin
            @(posedge clk);
            #1 lat++;
        end
    endtask

    task automatic run_op(input string tag, input logic [2:0] f,
                          input logic w, input logic [63:0] a,
                          input logic [63:0] b);
        int lat, exp_lat;
        exp_lat = is_special(f, w, a, b) ? 1 : (w ? 34 : 66);
        issue(f, w, a, b);
        wait_valid(lat);
        chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        chk({tag, "_res"}, out_result, model(f, w, a, b));
        @(posedge clk);
        #1;
    endtask

    initial begin
        int lat, cnt;
        logic [63:0] a, b, held;
        logic [2:0] f;
        logic w;
        rst_n = 1'b0;
        in_valid = 1'b0;
        op_1 = '0;
        op_2 = '0;
        funct3 = '0;
        is_w = 1'b0;
        flush = 1'b0;
        out_ready = 1'b1;
        #12;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_result", out_result, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("mul_7x-3", MD_MUL, 1'b0, 64'd7, -64'sd3);
        chk("mul_7x-3_const", model(MD_MUL, 1'b0, 64'd7, -64'sd3),
            64'hFFFF_FFFF_FFFF_FFEB);
        run_op("mulhu_ones", MD_MULHU, 1'b0, '1, '1);
        run_op("mulhsu", MD_MULHSU, 1'b0, '1, 64'd2);
        run_op("div_by0", MD_DIV, 1'b0, 64'd100, 64'd0);
        run_op("remu_by0", MD_REMU, 1'b0, 64'd100, 64'd0);
        run_op("div_ovf", MD_DIV, 1'b0, 64'h8000_0000_0000_0000, '1);
        run_op("rem_ovf", MD_REM, 1'b0, 64'h8000_0000_0000_0000, '1);
        run_op("divw", MD_DIV, 1'b1, 64'hDEAD_BEEF_FFFF_FFF9, 64'd2);
        chk("divw_const", model(MD_DIV, 1'b1, 64'hDEAD_BEEF_FFFF_FFF9, 64'd2),
            64'hFFFF_FFFF_FFFF_FFFD);
        run_op("remw", MD_REM, 1'b1, 64'hDEAD_BEEF_FFFF_FFF9, 64'd2);
        run_op("divw_ovf", MD_DIV, 1'b1, 64'h1234_5678_8000_0000,
               64'h0000_0000_FFFF_FFFF);
        run_op("remuw_by0", MD_REMU, 1'b1, 64'h0000_0000_8000_0001, 64'd0);

        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 3))
                0: a = {$urandom, $urandom};
                1: a = 64'($urandom_range(0, 1000));
                2: a = ($urandom_range(0, 1) != 0) ? 64'h8000_0000_0000_0000
                                                   : 64'hFFFF_FFFF_8000_0000;
                default: a = -64'($urandom_range(1, 1000));
            endcase
            case ($urandom_range(0, 7))
                0: b = '0;
                1: b = '1;
                2: b = 64'($urandom_range(1, 50));
                3: b = -64'($urandom_range(1, 50));
                default: b = {$urandom, $urandom};
            endcase
            f = 3'($urandom_range(0, 7));
            w = 1'($urandom_range(0, 1));
            run_op($sformatf("rnd%0d_f%0d_w%0d", i, f, w), f, w, a, b);
        end

        issue(MD_MUL, 1'b0, 64'd123, 64'd456);
        repeat (10) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        chk("flush_in_ready", 64'(in_ready), 64'd1);
        cnt = 0;
        repeat (100) begin
            @(negedge clk);
            if (out_valid) cnt++;
        end
        chk("flush_no_valid", 64'(cnt), 64'd0);

        out_ready = 1'b0;
        issue(MD_DIVU, 1'b0, 64'd1000, 64'd7);
        wait_valid(lat);
        chk("hold_lat", 64'(lat), 64'd66);
        held = out_result;
        chk("hold_res", held, 64'd142);
        repeat (5) begin
            @(posedge clk);
            #1;
            chk("hold_valid", 64'(out_valid), 64'd1);
            chk("hold_stable", out_result, 64'd142);
        end
        @(negedge clk);
        out_ready = 1'b1;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            if (out_valid && out_ready) cnt++;
            @(negedge clk);
        end
        chk("hold_xfers", 64'(cnt), 64'd1);

        issue(MD_MULH, 1'b0, 64'd5, 64'd9);
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_in_ready", 64'(in_ready), 64'd1);
        chk("arst_out_valid", 64'(out_valid), 64'd0);
        chk("arst_out_result", out_result, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op("post_rst_rem", MD_REM, 1'b0, -64'sd17, 64'd5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
